// File: rtl/rsnn_neuron_param.sv
// -----------------------------------------------------------------------------
// rsnn_neuron_param
//
// Recurrent leaky-integrate-and-fire neuron. The signed membrane potential
// leaks toward zero by `decay` on every enabled update, integrates the external
// current plus its own spike fed back after FB_DELAY enabled updates, and fires
// when the saturated next potential reaches `threshold`. After a spike the
// neuron ignores `refractory_period` enabled updates.
//
// Parameters:
//   WIDTH     data width of current/potential/threshold/decay/feedback
//   REFR_W    width of refractory period and counter
//   FB_DELAY  spike-to-feedback delay in enabled updates (1..8)
//   CNT_W     spike counter width
//
// Ports:
//   clk               rising-edge clock
//   rst_n             synchronous active-low reset
//   enable            update strobe; state holds while low
//   ext_current       signed external current
//   threshold         signed firing threshold
//   decay             unsigned leak magnitude per update
//   refractory_period enabled updates ignored after a spike
//   feedback_scale    signed weight of the delayed own spike
//   clr_count         synchronous clear of spike_count
//   spike_out         one-cycle registered spike pulse
//   membrane          signed membrane potential register
//   in_refractory     high while in the refractory state
//   spike_count       saturating spike count
//
// Optional build macro RSNN_NEURON_TEST_EN adds:
//   sel_test          selects the observation source
//   out_test          sel_test ? refractory counter : membrane (combinational)
// -----------------------------------------------------------------------------
module rsnn_neuron_param #(
    parameter int WIDTH    = 8,
    parameter int REFR_W   = 8,
    parameter int FB_DELAY = 1,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [WIDTH-1:0]  ext_current,
    input  logic [WIDTH-1:0]  threshold,
    input  logic [WIDTH-1:0]  decay,
    input  logic [REFR_W-1:0] refractory_period,
    input  logic [WIDTH-1:0]  feedback_scale,
    input  logic              clr_count,
`ifdef RSNN_NEURON_TEST_EN
    input  logic              sel_test,
    output logic [WIDTH-1:0]  out_test,
`endif
    output logic              spike_out,
    output logic [WIDTH-1:0]  membrane,
    output logic              in_refractory,
    output logic [CNT_W-1:0]  spike_count
);

    typedef enum logic [0:0] {
        ST_INTEGRATE  = 1'b0,
        ST_REFRACTORY = 1'b1
    } state_t;

    // Clamp bounds expressed at WIDTH+1 bits so sums can be compared directly.
    localparam logic signed [WIDTH:0] SAT_MAX_C = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0] SAT_MIN_C = {2'b11, {(WIDTH-1){1'b0}}};

    // Clamp a WIDTH+1 bit signed sum into the WIDTH bit signed range.
    function automatic logic [WIDTH-1:0] sat_f(input logic signed [WIDTH:0] val);
        logic [WIDTH-1:0] res;
        if (val > SAT_MAX_C) begin
            res = SAT_MAX_C[WIDTH-1:0];
        end else if (val < SAT_MIN_C) begin
            res = SAT_MIN_C[WIDTH-1:0];
        end else begin
            res = val[WIDTH-1:0];
        end
        return res;
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic [WIDTH-1:0]    membrane_r;
    logic [WIDTH-1:0]    membrane_next_s;
    logic [REFR_W-1:0]   refr_cnt_r;
    logic [REFR_W-1:0]   refr_cnt_next_s;
    logic [FB_DELAY-1:0] fb_line_r;
    logic [FB_DELAY-1:0] fb_line_next_s;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    count_next_s;
    logic                spike_r;
    logic                in_refr_r;

    logic                fb_spike_s;
    logic [WIDTH-1:0]    fb_term_s;
    logic signed [WIDTH:0]   i_sum_s;
    logic [WIDTH-1:0]    i_total_s;
    logic signed [WIDTH+1:0] v_wide_s;
    logic signed [WIDTH+1:0] dec_wide_s;
    logic [WIDTH-1:0]    v_leak_s;
    logic signed [WIDTH:0]   v_sum_s;
    logic [WIDTH-1:0]    v_next_s;
    logic                fire_s;

    // Integration datapath: feedback, saturated current, leak and firing test.
    always_comb begin
        fb_spike_s = fb_line_r[FB_DELAY-1];
        if (fb_spike_s) begin
            fb_term_s = feedback_scale;
        end else begin
            fb_term_s = {WIDTH{1'b0}};
        end
        i_sum_s   = {ext_current[WIDTH-1], ext_current} + {fb_term_s[WIDTH-1], fb_term_s};
        i_total_s = sat_f(i_sum_s);

        // Leak is decided at WIDTH+2 bits so -decay never overflows; the
        // selected result always fits in WIDTH bits, so it is formed narrow.
        v_wide_s   = {{2{membrane_r[WIDTH-1]}}, membrane_r};
        dec_wide_s = {2'b00, decay};
        if (v_wide_s > dec_wide_s) begin
            v_leak_s = membrane_r - decay;
        end else if (v_wide_s < -dec_wide_s) begin
            v_leak_s = membrane_r + decay;
        end else begin
            v_leak_s = {WIDTH{1'b0}};
        end

        v_sum_s  = {v_leak_s[WIDTH-1], v_leak_s} + {i_total_s[WIDTH-1], i_total_s};
        v_next_s = sat_f(v_sum_s);

        if (enable && (state_r == ST_INTEGRATE) && ($signed(v_next_s) >= $signed(threshold))) begin
            fire_s = 1'b1;
        end else begin
            fire_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_INTEGRATE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a zero refractory period keeps the neuron integrating.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INTEGRATE: begin
                if (fire_s && (refractory_period != {REFR_W{1'b0}})) begin
                    state_next_s = ST_REFRACTORY;
                end else begin
                    state_next_s = ST_INTEGRATE;
                end
            end
            ST_REFRACTORY: begin
                // A stray zero count also leaves, so the state can never stick.
                if (enable && (refr_cnt_r <= REFR_W'(1'b1))) begin
                    state_next_s = ST_INTEGRATE;
                end else begin
                    state_next_s = ST_REFRACTORY;
                end
            end
            default: begin
                state_next_s = ST_INTEGRATE;
            end
        endcase
    end

    // Next values of membrane, refractory counter, delay line and spike count.
    always_comb begin
        membrane_next_s = membrane_r;
        refr_cnt_next_s = refr_cnt_r;
        fb_line_next_s  = fb_line_r;
        count_next_s    = count_r;

        if (enable) begin
            case (state_r)
                ST_INTEGRATE: begin
                    if (fire_s) begin
                        membrane_next_s = {WIDTH{1'b0}};
                        refr_cnt_next_s = refractory_period;
                    end else begin
                        membrane_next_s = v_next_s;
                    end
                end
                ST_REFRACTORY: begin
                    membrane_next_s = {WIDTH{1'b0}};
                    if (refr_cnt_r != {REFR_W{1'b0}}) begin
                        refr_cnt_next_s = refr_cnt_r - REFR_W'(1'b1);
                    end else begin
                        refr_cnt_next_s = {REFR_W{1'b0}};
                    end
                end
                default: begin
                    membrane_next_s = {WIDTH{1'b0}};
                end
            endcase
            // Delay line only advances on enabled updates.
            for (int k = FB_DELAY - 1; k > 0; k--) begin
                fb_line_next_s[k] = fb_line_r[k-1];
            end
            fb_line_next_s[0] = fire_s;
        end else begin
            membrane_next_s = membrane_r;
        end

        if (clr_count) begin
            count_next_s = {CNT_W{1'b0}};
        end else if (fire_s && (count_r != {CNT_W{1'b1}})) begin
            count_next_s = count_r + CNT_W'(1'b1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            membrane_r <= {WIDTH{1'b0}};
            refr_cnt_r <= {REFR_W{1'b0}};
            fb_line_r  <= {FB_DELAY{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            spike_r    <= 1'b0;
            in_refr_r  <= 1'b0;
        end else begin
            membrane_r <= membrane_next_s;
            refr_cnt_r <= refr_cnt_next_s;
            fb_line_r  <= fb_line_next_s;
            count_r    <= count_next_s;
            spike_r    <= fire_s;
            in_refr_r  <= (state_next_s == ST_REFRACTORY);
        end
    end

    assign spike_out     = spike_r;
    assign membrane      = membrane_r;
    assign in_refractory = in_refr_r;
    assign spike_count   = count_r;

`ifdef RSNN_NEURON_TEST_EN
    logic [WIDTH-1:0] refr_view_s;

    if (REFR_W >= WIDTH) begin : g_refr_trunc
        assign refr_view_s = refr_cnt_r[WIDTH-1:0];
    end else begin : g_refr_ext
        assign refr_view_s = {{(WIDTH-REFR_W){1'b0}}, refr_cnt_r};
    end

    assign out_test = sel_test ? refr_view_s : membrane_r;
`endif

endmodule

// File: tb/tb_rsnn_neuron_param.sv
// -----------------------------------------------------------------------------
// tb_rsnn_neuron_param
//
// Directed scenarios followed by random stimulus, each update checked against
// an integer reference model of the neuron rules. WIDTH=8, FB_DELAY=2.
// -----------------------------------------------------------------------------
module tb_rsnn_neuron_param;

    localparam int WIDTH    = 8;
    localparam int REFR_W   = 8;
    localparam int FB_DELAY = 2;
    localparam int CNT_W    = 8;
    localparam int VMAX     = 127;
    localparam int VMIN     = -128;
    localparam int CMAX     = 255;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     enable;
    logic signed [WIDTH-1:0]  ext_current;
    logic signed [WIDTH-1:0]  threshold;
    logic [WIDTH-1:0]         decay;
    logic [REFR_W-1:0]        refractory_period;
    logic signed [WIDTH-1:0]  feedback_scale;
    logic                     clr_count;
    logic                     spike_out;
    logic signed [WIDTH-1:0]  membrane;
    logic                     in_refractory;
    logic [CNT_W-1:0]         spike_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int m_v;
    int m_refr;
    bit m_inref;
    int m_cnt;
    bit m_spike;
    bit m_hist[FB_DELAY];   // m_hist[0] = fire of the most recent enabled update

    rsnn_neuron_param #(
        .WIDTH(WIDTH), .REFR_W(REFR_W), .FB_DELAY(FB_DELAY), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .ext_current(ext_current),
        .threshold(threshold),
        .decay(decay),
        .refractory_period(refractory_period),
        .feedback_scale(feedback_scale),
        .clr_count(clr_count),
        .spike_out(spike_out),
        .membrane(membrane),
        .in_refractory(in_refractory),
        .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    // Single comparison point for every check.
    task automatic check_value(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clampv(input int x);
        if (x > VMAX) return VMAX;
        if (x < VMIN) return VMIN;
        return x;
    endfunction

    // One update of the neuron rules using the inputs currently applied.
    task automatic model_step();
        int  i_tot;
        int  v_l;
        int  v_n;
        int  dec;
        bit  fired;
        fired   = 1'b0;
        m_spike = 1'b0;
        if (!rst_n) begin
            m_v = 0; m_refr = 0; m_inref = 1'b0; m_cnt = 0;
            for (int k = 0; k < FB_DELAY; k++) m_hist[k] = 1'b0;
            return;
        end
        if (enable) begin
            if (!m_inref) begin
                i_tot = clampv(int'(ext_current) + (m_hist[FB_DELAY-1] ? int'(feedback_scale) : 0));
                dec   = int'(decay);
                if (m_v > dec)       v_l = m_v - dec;
                else if (m_v < -dec) v_l = m_v + dec;
                else                 v_l = 0;
                v_n = clampv(v_l + i_tot);
                if (v_n >= int'(threshold)) begin
                    fired   = 1'b1;
                    m_v     = 0;
                    m_refr  = int'(refractory_period);
                    m_inref = (refractory_period != 0);
                    if (m_cnt < CMAX) m_cnt++;
                end else begin
                    m_v = v_n;
                end
            end else begin
                m_v = 0;
                if (m_refr <= 1) m_inref = 1'b0;
                if (m_refr > 0) m_refr--;
            end
            for (int k = FB_DELAY - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = fired;
        end
        m_spike = fired;
        if (clr_count) m_cnt = 0;
    endtask

    // Apply one clock with the present inputs and compare all outputs.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_value("spike_out", spike_out, m_spike);
        check_value("membrane", membrane, m_v);
        check_value("in_refractory", in_refractory, m_inref);
        check_value("spike_count", spike_count, m_cnt);
    endtask

    task automatic set_in(input int ext, input int thr, input int dec, input int rp, input int fb);
        ext_current       = WIDTH'(ext);
        threshold         = WIDTH'(thr);
        decay             = WIDTH'(dec);
        refractory_period = REFR_W'(rp);
        feedback_scale    = WIDTH'(fb);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        m_v = 0; m_refr = 0; m_inref = 1'b0; m_cnt = 0; m_spike = 1'b0;
        for (int k = 0; k < FB_DELAY; k++) m_hist[k] = 1'b0;
        enable    = 1'b1;
        clr_count = 1'b0;
        set_in(0, 0, 0, 0, 0);
        do_reset();

        // Integration: 20, 40, then fire.
        set_in(20, 50, 0, 0, 0);
        tick();
        check_value("integ_20", membrane, 20);
        tick();
        tick();
        check_value("integ_spike", spike_out, 1);
        check_value("integ_count", spike_count, 1);
        check_value("integ_zero", membrane, 0);

        // Leak from +40 and from -40.
        set_in(40, 127, 0, 0, 0);
        tick();
        set_in(0, 127, 15, 0, 0);
        tick();
        check_value("leak_25", membrane, 25);
        for (int i = 0; i < 3; i++) tick();
        check_value("leak_pos_zero", membrane, 0);
        set_in(-40, 127, 0, 0, 0);
        tick();
        set_in(0, 127, 15, 0, 0);
        tick();
        tick();
        check_value("leak_neg10", membrane, -10);
        tick();
        check_value("leak_neg_zero", membrane, 0);

        // Refractory with one disabled cycle in the middle.
        set_in(20, 30, 0, 3, 0);
        tick();
        tick();
        check_value("refr_spike", spike_out, 1);
        check_value("refr_enter", in_refractory, 1);
        for (int i = 0; i < 8; i++) begin
            enable = (i != 1);
            tick();
        end
        enable = 1'b1;

        // Reset while refractory.
        for (int i = 0; i < 10 && !m_inref; i++) tick();
        check_value("pre_rst_inref", in_refractory, 1);
        do_reset();
        check_value("rst_inref", in_refractory, 0);
        check_value("rst_count", spike_count, 0);
        check_value("rst_membrane", membrane, 0);

        // Saturation of current and of membrane.
        set_in(127, 127, 0, 0, 127);
        tick();
        check_value("sat_fire", spike_out, 1);
        tick();
        tick();
        set_in(-128, 127, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        check_value("sat_min", membrane, -128);

        // Delayed inhibitory feedback.
        do_reset();
        set_in(20, 40, 0, 0, -30);
        tick();
        tick();
        check_value("fb_spike", spike_out, 1);
        tick();
        check_value("fb_not_yet", membrane, 20);
        tick();
        check_value("fb_inhib", membrane, 10);
        tick();

        // Counter saturation and clear.
        set_in(0, -128, 0, 0, 0);
        for (int i = 0; i < 260; i++) tick();
        check_value("cnt_sat", spike_count, 255);
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check_value("cnt_clr", spike_count, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            enable    = ($urandom_range(0, 4) != 0);
            clr_count = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 7) == 0) begin
                set_in($signed(8'($urandom_range(0, 255))), $signed(8'($urandom_range(0, 255))),
                       $urandom_range(0, 40), $urandom_range(0, 4), $signed(8'($urandom_range(0, 255))));
            end else begin
                set_in($urandom_range(0, 80) - 30, $urandom_range(10, 120),
                       $urandom_range(0, 20), $urandom_range(0, 4), $urandom_range(0, 160) - 80);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
